l2_cache_assoc: RTL and testbench
=================================

# l2_cache_assoc

Parametrised, set-associative, write-back, write-allocate L2 cache that sits between the L1 cache and main memory. It holds one LINE_W-bit line per way per set and uses true-LRU replacement with invalid-way preference and dirty-line writeback. It also keeps access and miss counters for performance measurement. With WAYS=1 it behaves as a direct-mapped write-back L2.

## Interface
- ADDR_W, 28, line-address width (both L1 side and memory side)
- LINE_W, 128, line/data width
- SET_BITS, 5, index width; SETS = 2**SET_BITS; TAG_W = ADDR_W-SET_BITS
- WAYS, 2, associativity; legal values 1, 2, 4, 8
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- l2_read  in  1  L1 read request
- l2_write  in  1  L1 write request (full line)
- l2_addr  in  ADDR_W  line address; index = [SET_BITS-1:0], tag = [ADDR_W-1:SET_BITS]
- l2_wdata  in  LINE_W  write line
- l2_rdata  out  LINE_W  read line; valid when l2_ready=1 and read accepted, else 0
- l2_ready  out  1  combinational request-complete
- mem_read, mem_write  out  1  registered memory requests
- mem_addr  out  ADDR_W  registered memory line address
- mem_wdata  out  LINE_W  registered writeback data
- mem_rdata  in  LINE_W  refill data, valid with mem_ready
- mem_ready  in  1  memory completes current request
- access_cnt  out  32  accepted requests, wraps
- miss_cnt  out  32  misses detected, wraps

## Operation
- Per way, per set: valid, dirty, tag, line. Per set, a log2(WAYS)-bit age per way; age 0 = MRU.
- States: IDLE, WRITEBACK, REFILL.
- Request rules:
  - A request is exactly one of l2_read/l2_write.
  - Both high, or neither: no operation; l2_ready=1; no state change.
  - L1 holds addr/wdata stable until l2_ready=1.
- IDLE, hit (valid && tag match in any way):
  - l2_ready=1.
  - Read: l2_rdata = hit line.
  - Write: line <= l2_wdata, dirty <= 1.
  - Hit way becomes MRU; ways with age below its old age increment.
  - access_cnt++.
- IDLE, miss:
  - l2_ready=0; miss_cnt++.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - Victim valid && dirty: mem_write<=1, mem_addr<={victim tag, index}, mem_wdata<=victim line; go WRITEBACK.
  - Otherwise: mem_read<=1, mem_addr<=l2_addr; go REFILL.
- WRITEBACK: l2_ready=0. On mem_ready: mem_write<=0, mem_read<=1, mem_addr<=l2_addr; go REFILL.
- REFILL: l2_ready=0. On mem_ready:
  - mem_read<=0.
  - Victim <= {valid=1, dirty=0, tag, mem_rdata}; victim becomes MRU.
  - Go IDLE. The request then hits (write hit merges data and sets dirty).
- Victim way is latched on entering WRITEBACK/REFILL and not recomputed.
- mem_ready is ignored while mem_read=mem_write=0.
- mem_read and mem_write are never high together.

## Timing
- Reset values:
  - all valid/dirty bits 0; set ages way i = i; state IDLE.
  - mem_read/mem_write 0; mem_addr 0; mem_wdata 0; counters 0.
  - l2_rdata 0; l2_ready 1 if no request is present.
- Hit latency: 0 cycles; l2_ready high in the request cycle.
- Clean miss:
  - cycle 0: miss detected.
  - cycle 1: mem_read=1.
  - mem_ready at cycle k: cycle k+1 is IDLE and l2_ready=1.
- Dirty miss: adds one full memory write transaction before the read.
- Memory request outputs stay asserted and stable until the mem_ready cycle; they deassert the following cycle.
- Reset mid-transaction: all outputs and state clear immediately (asynchronous); the aborted memory request is dropped and contents are invalidated.

## Test plan
- Reset, then read 0x0000020:
  - Required: mem_read=1 with mem_addr=0x0000020.
  - Drive mem_ready with mem_rdata=0xA5A5...A5.
  - Next cycle: l2_ready=1, l2_rdata=0xA5...A5; miss_cnt=1, access_cnt=1.
- WAYS=2, set 0, read tags 1, 2, 1, then 3:
  - Tag 3 evicts tag 2 (LRU).
  - Only mem_read is issued, no mem_write; a later tag 1 read hits with zero wait.
- Write 0xDEAD...BEEF to 0x0000040 (hit, after fill), then miss set 0 with both ways dirty:
  - mem_write with mem_addr = LRU line address and its data.
  - After mem_ready: mem_read of the new address follows.
- l2_read=l2_write=1 on a resident address: l2_ready=1, line and counters unchanged.
- Assert reset while in REFILL with mem_read=1:
  - mem_read=0 in the same cycle.
  - After release, a read of the same address misses again (miss_cnt=1).
- WAYS=1, SET_BITS=5: addresses 0x0000021 then 0x0000041 alternate and miss every access.

Source files
------------

// File: rtl/l2_cache_assoc.sv
// Set-associative write-back, write-allocate L2 cache with true-LRU replacement,
// invalid-way preference, dirty-line writeback and access/miss counters.
module l2_cache_assoc #(
   parameter int ADDR_W   = 28,
   parameter int LINE_W   = 128,
   parameter int SET_BITS = 5,
   parameter int WAYS     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              l2_read,
   input  logic              l2_write,
   input  logic [ADDR_W-1:0] l2_addr,
   input  logic [LINE_W-1:0] l2_wdata,
   output logic [LINE_W-1:0] l2_rdata,
   output logic              l2_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       access_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_W - SET_BITS;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

   state_t state_q, state_d;

   logic [SETS-1:0]   valid_q [WAYS];
   logic [SETS-1:0]   dirty_q [WAYS];
   logic [WAY_W-1:0]  age_q   [WAYS][SETS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [LINE_W-1:0] line_q  [WAYS][SETS];

   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [WAY_W-1:0]  victim_q,    victim_d;
   logic [31:0]       access_q,    miss_q;

   logic [SET_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag;
   logic                req;
   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic [WAY_W-1:0]    vict_way;
   logic                vict_found;
   logic                acc_inc, miss_inc;
   logic                wr_hit, fill;
   logic                line_we;
   logic [WAY_W-1:0]    line_way;
   logic [LINE_W-1:0]   line_wdata;
   logic                touch_en;
   logic [WAY_W-1:0]    touch_way;
   logic [WAY_W-1:0]    age_new [WAYS];

   assign idx = l2_addr[SET_BITS-1:0];
   assign tag = l2_addr[ADDR_W-1:SET_BITS];
   assign req = l2_read ^ l2_write;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Replacement: lowest-index invalid way first, otherwise the LRU way.
   always_comb begin
      vict_found = 1'b0;
      vict_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!vict_found && !valid_q[w][idx]) begin
            vict_found = 1'b1;
            vict_way   = WAY_W'(w);
         end
      end
      if (!vict_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[w][idx] == WAY_W'(WAYS - 1)) vict_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      victim_d    = victim_q;
      l2_ready    = 1'b0;
      l2_rdata    = '0;
      acc_inc     = 1'b0;
      miss_inc    = 1'b0;
      wr_hit      = 1'b0;
      fill        = 1'b0;
      line_we     = 1'b0;
      line_way    = hit_way;
      line_wdata  = l2_wdata;
      touch_en    = 1'b0;
      touch_way   = hit_way;
      case (state_q)
         S_IDLE: begin
            if (!req) begin
               l2_ready = 1'b1;
            end else if (hit) begin
               l2_ready = 1'b1;
               acc_inc  = 1'b1;
               touch_en = 1'b1;
               if (l2_read) l2_rdata = line_q[hit_way][idx];
               if (l2_write) begin
                  wr_hit  = 1'b1;
                  line_we = 1'b1;
               end
            end else begin
               miss_inc = 1'b1;
               victim_d = vict_way;
               if (valid_q[vict_way][idx] && dirty_q[vict_way][idx]) begin
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[vict_way][idx], idx};
                  mem_wdata_d = line_q[vict_way][idx];
                  state_d     = S_WRITEBACK;
               end else begin
                  mem_read_d = 1'b1;
                  mem_addr_d = l2_addr;
                  state_d    = S_REFILL;
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) begin
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = l2_addr;
               state_d     = S_REFILL;
            end
         end
         S_REFILL: begin
            if (mem_ready) begin
               mem_read_d = 1'b0;
               fill       = 1'b1;
               line_we    = 1'b1;
               line_way   = victim_q;
               line_wdata = mem_rdata;
               touch_en   = 1'b1;
               touch_way  = victim_q;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Touched way becomes MRU; ways younger than its old age shift down by one.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         age_new[w] = age_q[w][idx];
         if (touch_en) begin
            if (WAY_W'(w) == touch_way) age_new[w] = '0;
            else if (age_q[w][idx] < age_q[touch_way][idx]) age_new[w] = age_q[w][idx] + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         victim_q    <= '0;
         access_q    <= '0;
         miss_q      <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
            for (int s = 0; s < SETS; s++) age_q[w][s] <= WAY_W'(w);
         end
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         victim_q    <= victim_d;
         if (acc_inc)  access_q <= access_q + 32'd1;
         if (miss_inc) miss_q   <= miss_q + 32'd1;
         if (fill) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
         end
         if (wr_hit) dirty_q[hit_way][idx] <= 1'b1;
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) age_q[w][idx] <= age_new[w];
         end
      end
   end

   // NOTE: tag/line storage is not reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (line_we) line_q[line_way][idx] <= line_wdata;
      if (fill)    tag_q[victim_q][idx]  <= tag;
   end

   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign access_cnt = access_q;
   assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc: a 2-way instance and a direct-mapped
// instance share one stimulus/memory-response path selected by sel.
module tb_l2_cache_assoc;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd, wr, mr, sel;
   logic [27:0]  addr;
   logic [127:0] wdata, mrdata;

   logic [127:0] r0_rdata, r0_mwdata, r1_rdata, r1_mwdata;
   logic [27:0]  r0_maddr, r1_maddr;
   logic         r0_ready, r0_mread, r0_mwrite, r1_ready, r1_mread, r1_mwrite;
   logic [31:0]  r0_acc, r0_miss, r1_acc, r1_miss;

   logic [127:0] o_rdata, o_mwdata;
   logic [27:0]  o_maddr;
   logic         o_ready, o_mread, o_mwrite;
   logic [31:0]  o_acc, o_miss;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [127:0] D_A5   = {16{8'hA5}};
   localparam logic [127:0] D_B    = {16{8'hB6}};
   localparam logic [127:0] D_C    = {16{8'hC7}};
   localparam logic [127:0] D_D    = {16{8'hD8}};
   localparam logic [127:0] D_E    = {16{8'hE9}};
   localparam logic [127:0] D_F    = {16{8'hF1}};
   localparam logic [127:0] D_BEEF = {4{32'hDEADBEEF}};

   always #5 clk = ~clk;

   l2_cache_assoc #(.ADDR_W(28), .LINE_W(128), .SET_BITS(5), .WAYS(2)) u_dut (
      .clk(clk), .reset(reset),
      .l2_read(rd & ~sel), .l2_write(wr & ~sel), .l2_addr(addr), .l2_wdata(wdata),
      .l2_rdata(r0_rdata), .l2_ready(r0_ready),
      .mem_read(r0_mread), .mem_write(r0_mwrite), .mem_addr(r0_maddr), .mem_wdata(r0_mwdata),
      .mem_rdata(mrdata), .mem_ready(mr & ~sel),
      .access_cnt(r0_acc), .miss_cnt(r0_miss)
   );

   l2_cache_assoc #(.ADDR_W(28), .LINE_W(128), .SET_BITS(5), .WAYS(1)) u_dm (
      .clk(clk), .reset(reset),
      .l2_read(rd & sel), .l2_write(wr & sel), .l2_addr(addr), .l2_wdata(wdata),
      .l2_rdata(r1_rdata), .l2_ready(r1_ready),
      .mem_read(r1_mread), .mem_write(r1_mwrite), .mem_addr(r1_maddr), .mem_wdata(r1_mwdata),
      .mem_rdata(mrdata), .mem_ready(mr & sel),
      .access_cnt(r1_acc), .miss_cnt(r1_miss)
   );

   assign o_rdata  = sel ? r1_rdata  : r0_rdata;
   assign o_ready  = sel ? r1_ready  : r0_ready;
   assign o_mread  = sel ? r1_mread  : r0_mread;
   assign o_mwrite = sel ? r1_mwrite : r0_mwrite;
   assign o_maddr  = sel ? r1_maddr  : r0_maddr;
   assign o_mwdata = sel ? r1_mwdata : r0_mwdata;
   assign o_acc    = sel ? r1_acc    : r0_acc;
   assign o_miss   = sel ? r1_miss   : r0_miss;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic r, input logic w, input logic [27:0] a, input logic [127:0] d);
      rd = r; wr = w; addr = a; wdata = d;
      #1;
   endtask

   task automatic drop();
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      #1;
   endtask

   // Wait for a memory request, check it, then complete it with one mem_ready pulse.
   task automatic serve(input string tag, input logic exp_wr, input logic [27:0] exp_addr,
                        input logic [127:0] exp_wd, input logic [127:0] rdat);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (o_mread | o_mwrite) seen = 1'b1;
      end
      chk({tag, "_seen"}, 128'(seen), 128'd1);
      if (seen) begin
         chk({tag, "_mwrite"}, 128'(o_mwrite), 128'(exp_wr));
         chk({tag, "_mread"},  128'(o_mread),  128'(!exp_wr));
         chk({tag, "_maddr"},  128'(o_maddr),  128'(exp_addr));
         if (exp_wr) chk({tag, "_mwdata"}, o_mwdata, exp_wd);
         chk({tag, "_stall"}, 128'(o_ready), 128'd0);
         mr = 1'b1; mrdata = rdat;
         @(negedge clk);
         mr = 1'b0;
         #1;
         if (!exp_wr) chk({tag, "_mread_drop"}, 128'(o_mread), 128'd0);
      end
   endtask

   task automatic hit(input string tag, input logic r, input logic w, input logic [27:0] a,
                      input logic [127:0] d, input logic [127:0] exp_rd);
      @(negedge clk);
      req(r, w, a, d);
      chk({tag, "_ready"}, 128'(o_ready), 128'd1);
      chk({tag, "_rdata"}, o_rdata, exp_rd);
      drop();
   endtask

   task automatic miss_read(input string tag, input logic [27:0] a, input logic [127:0] rdat);
      @(negedge clk);
      req(1'b1, 1'b0, a, '0);
      chk({tag, "_wait"}, 128'(o_ready), 128'd0);
      serve(tag, 1'b0, a, '0, rdat);
      chk({tag, "_ready"}, 128'(o_ready), 128'd1);
      chk({tag, "_rdata"}, o_rdata, rdat);
      drop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [27:0] dm_addr [4];
      dm_addr[0] = 28'h21; dm_addr[1] = 28'h41; dm_addr[2] = 28'h21; dm_addr[3] = 28'h41;

      reset = 1'b1; rd = 1'b0; wr = 1'b0; mr = 1'b0; sel = 1'b0;
      addr = '0; wdata = '0; mrdata = '0;
      #1;
      chk("rst_ready",  128'(o_ready),  128'd1);
      chk("rst_rdata",  o_rdata,        '0);
      chk("rst_mread",  128'(o_mread),  128'd0);
      chk("rst_mwrite", 128'(o_mwrite), 128'd0);
      chk("rst_maddr",  128'(o_maddr),  128'd0);
      chk("rst_acc",    128'(o_acc),    128'd0);
      chk("rst_miss",   128'(o_miss),   128'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Cold read miss into set 0 (tag 1 -> way 0).
      miss_read("cold", 28'h20, D_A5);
      chk("cold_acc",  128'(o_acc),  128'd1);
      chk("cold_miss", 128'(o_miss), 128'd1);

      // LRU: tag 2 fills way 1, tag 1 hits, tag 3 evicts clean tag 2.
      miss_read("t2", 28'h40, D_B);
      hit("t1_hit", 1'b1, 1'b0, 28'h20, '0, D_A5);
      miss_read("t3", 28'h60, D_C);
      hit("t1_hit2", 1'b1, 1'b0, 28'h20, '0, D_A5);
      chk("lru_acc",  128'(o_acc),  128'd5);
      chk("lru_miss", 128'(o_miss), 128'd3);

      // Write-allocate 0x40 over tag 3, then dirty tag 1 too.
      @(negedge clk);
      req(1'b0, 1'b1, 28'h40, D_BEEF);
      chk("wmiss_wait", 128'(o_ready), 128'd0);
      serve("wmiss", 1'b0, 28'h40, '0, D_D);
      chk("wmiss_ready", 128'(o_ready), 128'd1);
      chk("wmiss_rdata", o_rdata, '0);
      drop();
      hit("whit", 1'b0, 1'b1, 28'h20, D_E, '0);

      // Both ways dirty: tag 4 must write back LRU line 0x40 before refilling.
      @(negedge clk);
      req(1'b1, 1'b0, 28'h80, '0);
      chk("dirty_wait", 128'(o_ready), 128'd0);
      serve("wb", 1'b1, 28'h40, D_BEEF, '0);
      serve("wb_rf", 1'b0, 28'h80, '0, D_F);
      chk("dirty_ready", 128'(o_ready), 128'd1);
      chk("dirty_rdata", o_rdata, D_F);
      drop();
      chk("dirty_acc",  128'(o_acc),  128'd8);
      chk("dirty_miss", 128'(o_miss), 128'd5);

      // Read and write together: no operation.
      hit("both", 1'b1, 1'b1, 28'h20, {16{8'h11}}, '0);
      chk("both_acc",  128'(o_acc),  128'd8);
      chk("both_miss", 128'(o_miss), 128'd5);
      hit("both_line", 1'b1, 1'b0, 28'h20, '0, D_E);
      chk("post_acc", 128'(o_acc), 128'd9);

      // Reset while a refill is outstanding.
      @(negedge clk);
      req(1'b1, 1'b0, 28'h1E0, '0);
      @(negedge clk);
      chk("abort_mread_pre", 128'(o_mread), 128'd1);
      reset = 1'b1;
      #1;
      chk("abort_mread", 128'(o_mread), 128'd0);
      chk("abort_maddr", 128'(o_maddr), 128'd0);
      chk("abort_miss",  128'(o_miss),  128'd0);
      rd = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      miss_read("again", 28'h1E0, D_C);
      chk("again_miss", 128'(o_miss), 128'd1);
      chk("again_acc",  128'(o_acc),  128'd1);
      miss_read("inval", 28'h20, D_A5);

      // Direct-mapped instance: 0x21 and 0x41 share set 1 and thrash.
      @(negedge clk);
      sel = 1'b1;
      for (int i = 0; i < 4; i++) begin
         miss_read($sformatf("dm%0d", i), dm_addr[i], {16{8'(8'h30 + i)}});
      end
      chk("dm_miss", 128'(o_miss), 128'd4);
      chk("dm_acc",  128'(o_acc),  128'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
